// File: rtl/fpga_config_loader.sv
// Configuration loader for the programmable fabric: takes a byte stream, checks the
// sync byte, pad bits and XOR checksum, then commits the word and releases fabric reset.
module fpga_config_loader #(
  parameter int         CFG_BITS  = 116,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CFG_BITS-1:0] prog_out,
  output logic                fabric_reset,
  output logic                done,
  output logic                error
);

  localparam int NBYTES   = (CFG_BITS + 7) / 8;
  localparam int SH_W     = NBYTES * 8;
  localparam int PAD_BITS = SH_W - CFG_BITS;
  localparam int CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);
  // Pad bits occupy the top of the first payload byte.
  localparam logic [7:0] PAD_MASK = 8'(8'hFF << (8 - PAD_BITS));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LOAD,
    ST_CHECK,
    ST_RELEASE,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t           state;
  logic [SH_W-1:0]  shadow;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       acc;
  logic             pad_err;
  logic             accept;

  assign accept = in_valid & in_ready;

  function automatic logic pad_bad(input logic [7:0] b);
    return |(b & PAD_MASK);
  endfunction

  function automatic logic [SH_W-1:0] shift_in(input logic [SH_W-1:0] sh,
                                               input logic [7:0]      b);
    return {sh[SH_W-9:0], b};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      shadow       <= '0;
      cnt          <= '0;
      acc          <= '0;
      pad_err      <= 1'b0;
      prog_out     <= '0;
      fabric_reset <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      in_ready     <= 1'b0;
    end else if (start) begin
      // Restart from any state; a byte offered on this edge is dropped.
      state        <= ST_SYNC;
      cnt          <= '0;
      acc          <= '0;
      pad_err      <= 1'b0;
      fabric_reset <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b0;
        end
        ST_SYNC: begin
          if (accept && in_data == SYNC_BYTE) begin
            state   <= ST_LOAD;
            cnt     <= '0;
            acc     <= '0;
            pad_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            shadow <= shift_in(shadow, in_data);
            acc    <= acc ^ in_data;
            cnt    <= cnt + 1'b1;
            if (cnt == '0)
              pad_err <= pad_bad(in_data);
            if (cnt == LAST_IDX)
              state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data == acc && !pad_err) begin
              prog_out <= shadow[CFG_BITS-1:0];
              done     <= 1'b1;
              state    <= ST_RELEASE;
            end else begin
              error <= 1'b1;
              state <= ST_ERROR;
            end
          end
        end
        ST_RELEASE: begin
          // prog_out has settled for a full cycle before the fabric leaves reset.
          fabric_reset <= 1'b0;
          state        <= ST_DONE;
        end
        ST_DONE: begin
          in_ready <= 1'b0;
        end
        ST_ERROR: begin
          in_ready <= 1'b0;
        end
        default: begin
          state        <= ST_IDLE;
          in_ready     <= 1'b0;
          fabric_reset <= 1'b1;
          done         <= 1'b0;
          error        <= 1'b0;
        end
      endcase
    end
  end

  a_done_error_excl: assert property (@(posedge clk) disable iff (reset) !(done && error));
  a_run_needs_done:  assert property (@(posedge clk) disable iff (reset) !fabric_reset |-> done);

endmodule
